// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller and the
// branch condition evaluator.
package branch_redirect_ctrl_pkg;

    typedef logic [2:0] BranchType;

    localparam BranchType BRANCH_CODE_BEQ = 3'd0;
    localparam BranchType BRANCH_CODE_BNE = 3'd1;
    localparam BranchType BRANCH_CODE_BGE = 3'd2;
    localparam BranchType BRANCH_CODE_BGT = 3'd3;
    localparam BranchType BRANCH_CODE_BLE = 3'd4;
    localparam BranchType BRANCH_CODE_BLT = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAITDS = 2'd1,
        ST_REDIR  = 2'd2
    } StateType;

endpackage

// File: rtl/branch_redirect_ctrl_cond_eval.sv
// Combinational branch condition evaluator. Zero comparisons treat opA as
// signed; unknown codes resolve to not-taken.
module branch_cond_eval
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  BranchType        branchCode,
    input  logic [PC_W-1:0]  opA,
    input  logic [PC_W-1:0]  opB,
    output logic             taken
);

    logic aNeg;
    logic aZero;

    assign aNeg  = opA[PC_W-1];
    assign aZero = (opA == '0);

    // Decode the branch code into a taken decision.
    always_comb begin
        taken = 1'b0;
        case (branchCode)
            BRANCH_CODE_BEQ: taken = (opA == opB);
            BRANCH_CODE_BNE: taken = (opA != opB);
            BRANCH_CODE_BGE: taken = !aNeg;
            BRANCH_CODE_BGT: taken = !aNeg && !aZero;
            BRANCH_CODE_BLE: taken = aNeg || aZero;
            BRANCH_CODE_BLT: taken = aNeg;
            default:         taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch/exception redirect sequencer between EXE/MEM and PC/IF control.
// Optional statistics counters are enabled with the BRANCH_STAT_EN macro.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no redirect pending; taken branches are accepted
// ST_WAITDS | branch taken, waiting for the delay slot to reach ID
// ST_REDIR  | redirect held to PC until accepted; IF is flushed
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             exe_valid,
    input  logic             exe_is_branch,
    input  BranchType        exe_branch_code,
    input  logic [PC_W-1:0]  exe_opa,
    input  logic [PC_W-1:0]  exe_opb,
    input  logic [PC_W-1:0]  exe_target,
    input  logic             exe_stall,
    input  logic             id_valid,
    input  logic             exc_valid,
    input  logic [PC_W-1:0]  exc_target,
    output logic             redir_valid,
    output logic [PC_W-1:0]  redir_pc,
    input  logic             redir_ready,
    output logic             flush_if,
    output logic             flush_all,
`ifdef BRANCH_STAT_EN
    output logic [31:0]      stat_branch_cnt,
    output logic [31:0]      stat_taken_cnt,
`endif
    output logic             busy
);

    StateType        state;
    StateType        stateNext;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] targetNext;
    logic            taken;
    logic            branchSeen;
    logic            fire;

    branch_cond_eval #(.PC_W(PC_W)) uCondEval (
        .branchCode (exe_branch_code),
        .opA        (exe_opa),
        .opB        (exe_opb),
        .taken      (taken)
    );

    assign branchSeen = (state == ST_IDLE) && exe_valid && exe_is_branch && !exe_stall;
    assign fire       = branchSeen && taken;

    // State and redirect target registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            target <= '0;
        end else begin
            state  <= stateNext;
            target <= targetNext;
        end
    end

    // Next state; an exception overrides everything, including a same-cycle
    // redirect handshake, so the exception vector is never lost.
    always_comb begin
        stateNext  = state;
        targetNext = target;
        if (exc_valid) begin
            stateNext  = ST_REDIR;
            targetNext = exc_target;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        targetNext = exe_target;
                        stateNext  = id_valid ? ST_REDIR : ST_WAITDS;
                    end
                end
                ST_WAITDS: begin
                    if (id_valid) stateNext = ST_REDIR;
                end
                ST_REDIR: begin
                    if (redir_ready) stateNext = ST_IDLE;
                end
                default: stateNext = ST_IDLE;
            endcase
        end
    end

    // Moore outputs from registered state; flush_all is the only bypass.
    always_comb begin
        redir_valid = (state == ST_REDIR);
        flush_if    = (state == ST_REDIR);
        busy        = (state != ST_IDLE);
        redir_pc    = target;
        flush_all   = exc_valid;
    end

`ifdef BRANCH_STAT_EN
    // Branch and taken-branch counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_branch_cnt <= '0;
            stat_taken_cnt  <= '0;
        end else begin
            if (branchSeen) stat_branch_cnt <= stat_branch_cnt + 32'd1;
            if (fire)       stat_taken_cnt  <= stat_taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: stimulus pushes expected
// redirect addresses, a monitor pops them on every accepted redirect.
module tb_branch_redirect_ctrl;
    import branch_redirect_ctrl_pkg::*;

    logic        clk;
    logic        resetn;
    logic        exe_valid;
    logic        exe_is_branch;
    BranchType   exe_branch_code;
    logic [31:0] exe_opa;
    logic [31:0] exe_opb;
    logic [31:0] exe_target;
    logic        exe_stall;
    logic        id_valid;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic        flush_if;
    logic        flush_all;
    logic        busy;
`ifdef BRANCH_STAT_EN
    logic [31:0] stat_branch_cnt;
    logic [31:0] stat_taken_cnt;
`endif

    int nChecks = 0;
    int nErrors = 0;
    logic [31:0] expQ[$];

    typedef struct {
        BranchType   code;
        logic [31:0] a;
        logic [31:0] b;
        logic        tk;
    } VecT;

    VecT vecs[13];

    branch_redirect_ctrl #(.PC_W(32)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .exe_valid       (exe_valid),
        .exe_is_branch   (exe_is_branch),
        .exe_branch_code (exe_branch_code),
        .exe_opa         (exe_opa),
        .exe_opb         (exe_opb),
        .exe_target      (exe_target),
        .exe_stall       (exe_stall),
        .id_valid        (id_valid),
        .exc_valid       (exc_valid),
        .exc_target      (exc_target),
        .redir_valid     (redir_valid),
        .redir_pc        (redir_pc),
        .redir_ready     (redir_ready),
        .flush_if        (flush_if),
        .flush_all       (flush_all),
`ifdef BRANCH_STAT_EN
        .stat_branch_cnt (stat_branch_cnt),
        .stat_taken_cnt  (stat_taken_cnt),
`endif
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setBranch(input BranchType code, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] tgt);
        exe_valid       = 1'b1;
        exe_is_branch   = 1'b1;
        exe_branch_code = code;
        exe_opa         = a;
        exe_opb         = b;
        exe_target      = tgt;
    endtask

    task automatic clrBranch();
        exe_valid     = 1'b0;
        exe_is_branch = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; exe_valid = 0; exe_is_branch = 0; exe_branch_code = '0;
        exe_opa = '0; exe_opb = '0; exe_target = '0; exe_stall = 0;
        id_valid = 0; exc_valid = 0; exc_target = '0; redir_ready = 0;

        vecs[0]  = '{BRANCH_CODE_BGT, 32'h0000_0000, 32'h0, 1'b0};
        vecs[1]  = '{BRANCH_CODE_BNE, 32'h0000_0007, 32'h7, 1'b0};
        vecs[2]  = '{BRANCH_CODE_BGE, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[3]  = '{BRANCH_CODE_BLT, 32'h0000_0000, 32'h0, 1'b0};
        vecs[4]  = '{BRANCH_CODE_BLE, 32'h0000_0001, 32'h0, 1'b0};
        vecs[5]  = '{3'd6,            32'h0000_0005, 32'h5, 1'b0};
        vecs[6]  = '{3'd7,            32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[7]  = '{BRANCH_CODE_BEQ, 32'h0000_0005, 32'h6, 1'b0};
        vecs[8]  = '{BRANCH_CODE_BGE, 32'h0000_0000, 32'h0, 1'b1};
        vecs[9]  = '{BRANCH_CODE_BLE, 32'h8000_0000, 32'h0, 1'b1};
        vecs[10] = '{BRANCH_CODE_BGT, 32'h0000_0001, 32'h0, 1'b1};
        vecs[11] = '{BRANCH_CODE_BNE, 32'h0000_0001, 32'h2, 1'b1};
        vecs[12] = '{BRANCH_CODE_BLE, 32'h0000_0000, 32'h0, 1'b1};

        // Monitor: every accepted redirect must match the next expectation.
        fork
            forever begin
                @(negedge clk);
                if (redir_valid && redir_ready) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nErrors++;
                        $display("FAIL unexpected redirect: got pc %h expected none at %0t", redir_pc, $time);
                    end else begin
                        chk("redir_pc", redir_pc, expQ.pop_front());
                        chk("flush_if at redirect", {31'b0, flush_if}, 32'd1);
                    end
                end
            end
        join_none

        // Reset state.
        tick(); tick();
        chk("reset redir_valid", {31'b0, redir_valid}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset flush_if", {31'b0, flush_if}, 32'd0);
        chk("reset redir_pc", redir_pc, 32'd0);
        resetn = 1'b1;
        tick();

        // BEQ taken with delay slot present: redirect one cycle after fire.
        id_valid = 1; redir_ready = 1;
        setBranch(BRANCH_CODE_BEQ, 32'd5, 32'd5, 32'h8000_1000);
        expQ.push_back(32'h8000_1000);
        chk("beq busy before edge", {31'b0, busy}, 32'd0);
        tick();
        clrBranch();
        chk("beq redir_valid", {31'b0, redir_valid}, 32'd1);
        chk("beq redir_pc", redir_pc, 32'h8000_1000);
        chk("beq flush_if", {31'b0, flush_if}, 32'd1);
        chk("beq busy", {31'b0, busy}, 32'd1);
        tick();
        chk("beq idle redir_valid", {31'b0, redir_valid}, 32'd0);
        chk("beq idle flush_if", {31'b0, flush_if}, 32'd0);
        chk("beq idle busy", {31'b0, busy}, 32'd0);

        // Condition table: taken/not-taken across codes and sign boundaries.
        foreach (vecs[i]) begin
            setBranch(vecs[i].code, vecs[i].a, vecs[i].b, 32'h4000_0000 + 32'(i) * 32'h10);
            if (vecs[i].tk) expQ.push_back(32'h4000_0000 + 32'(i) * 32'h10);
            tick();
            clrBranch();
            chk($sformatf("vec%0d busy", i), {31'b0, busy}, {31'b0, vecs[i].tk});
            chk($sformatf("vec%0d redir_valid", i), {31'b0, redir_valid}, {31'b0, vecs[i].tk});
            if (vecs[i].tk) tick();
            chk($sformatf("vec%0d back idle", i), {31'b0, busy}, 32'd0);
        end

        // Stalled EXE never fires.
        exe_stall = 1;
        setBranch(BRANCH_CODE_BEQ, 32'd1, 32'd1, 32'h8000_0F00);
        tick();
        clrBranch(); exe_stall = 0;
        chk("stall no fire", {31'b0, busy}, 32'd0);

        // BLT with delay slot missing for 3 cycles.
        id_valid = 0;
        setBranch(BRANCH_CODE_BLT, 32'hFFFF_FFFF, 32'd0, 32'h8000_2000);
        expQ.push_back(32'h8000_2000);
        tick();
        setBranch(BRANCH_CODE_BEQ, 32'd1, 32'd1, 32'hDEAD_0000);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("waitds%0d busy", k), {31'b0, busy}, 32'd1);
            chk($sformatf("waitds%0d flush_if", k), {31'b0, flush_if}, 32'd0);
            chk($sformatf("waitds%0d redir_valid", k), {31'b0, redir_valid}, 32'd0);
            if (k < 2) tick();
        end
        id_valid = 1;
        tick();
        chk("waitds redir_valid", {31'b0, redir_valid}, 32'd1);
        chk("waitds redir_pc", redir_pc, 32'h8000_2000);
        clrBranch();
        tick();
        chk("waitds back idle", {31'b0, busy}, 32'd0);

        // Redirect held for 4 cycles without ready.
        redir_ready = 0;
        setBranch(BRANCH_CODE_BNE, 32'd1, 32'd2, 32'h8000_3000);
        expQ.push_back(32'h8000_3000);
        tick();
        clrBranch();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold%0d redir_valid", k), {31'b0, redir_valid}, 32'd1);
            chk($sformatf("hold%0d redir_pc", k), redir_pc, 32'h8000_3000);
            chk($sformatf("hold%0d busy", k), {31'b0, busy}, 32'd1);
            if (k < 3) tick();
        end
        redir_ready = 1;
        tick();
        chk("hold back idle", {31'b0, busy}, 32'd0);

        // Exception in the same cycle as a taken BNE: exception wins.
        redir_ready = 0;
        setBranch(BRANCH_CODE_BNE, 32'd3, 32'd4, 32'h8000_4000);
        exc_valid = 1; exc_target = 32'hBFC0_0380;
        expQ.push_back(32'hBFC0_0380);
        #1;
        chk("exc+br flush_all", {31'b0, flush_all}, 32'd1);
        tick();
        clrBranch(); exc_valid = 0;
        #1;
        chk("exc+br flush_all low", {31'b0, flush_all}, 32'd0);
        chk("exc+br redir_valid", {31'b0, redir_valid}, 32'd1);
        chk("exc+br redir_pc", redir_pc, 32'hBFC0_0380);
        redir_ready = 1;
        tick();
        chk("exc+br idle", {31'b0, busy}, 32'd0);
        tick();
        chk("exc+br branch dropped", {31'b0, busy}, 32'd0);

        // Exception arriving during WAIT_DS discards the pending branch.
        id_valid = 0;
        setBranch(BRANCH_CODE_BLT, 32'h8000_0000, 32'd0, 32'h8000_5000);
        tick();
        clrBranch();
        chk("excwait busy", {31'b0, busy}, 32'd1);
        chk("excwait redir_valid", {31'b0, redir_valid}, 32'd0);
        exc_valid = 1; exc_target = 32'hBFC0_0380;
        expQ.push_back(32'hBFC0_0380);
        #1;
        chk("excwait flush_all", {31'b0, flush_all}, 32'd1);
        tick();
        exc_valid = 0; id_valid = 1;
        chk("excwait redir_pc", redir_pc, 32'hBFC0_0380);
        tick();
        chk("excwait idle", {31'b0, busy}, 32'd0);

        // Exception during REDIR overwrites the held target.
        redir_ready = 0;
        setBranch(BRANCH_CODE_BEQ, 32'd9, 32'd9, 32'h8000_6000);
        tick();
        clrBranch();
        chk("excredir first pc", redir_pc, 32'h8000_6000);
        exc_valid = 1; exc_target = 32'hBFC0_0200;
        expQ.push_back(32'hBFC0_0200);
        tick();
        exc_valid = 0;
        chk("excredir redir_valid", {31'b0, redir_valid}, 32'd1);
        chk("excredir redir_pc", redir_pc, 32'hBFC0_0200);
        redir_ready = 1;
        tick();
        chk("excredir idle", {31'b0, busy}, 32'd0);

        // Reset asserted while a redirect is held.
        redir_ready = 0;
        setBranch(BRANCH_CODE_BGE, 32'd3, 32'd0, 32'h8000_7000);
        tick();
        clrBranch();
        chk("rst pre redir_valid", {31'b0, redir_valid}, 32'd1);
        resetn = 0; exc_valid = 1; exc_target = 32'hBFC0_0000;
        #1;
        chk("rst flush_all follows exc", {31'b0, flush_all}, 32'd1);
        tick();
        chk("rst redir_valid", {31'b0, redir_valid}, 32'd0);
        chk("rst flush_if", {31'b0, flush_if}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst redir_pc", redir_pc, 32'd0);
        chk("rst flush_all in reset", {31'b0, flush_all}, 32'd1);
        exc_valid = 0; resetn = 1;
        tick();
        chk("rst stays idle", {31'b0, busy}, 32'd0);

`ifdef BRANCH_STAT_EN
        // 10 branches, 4 taken (i = 0, 3, 6, 9).
        redir_ready = 1; id_valid = 1;
        for (int i = 0; i < 10; i++) begin
            setBranch(BRANCH_CODE_BEQ, 32'd1, (i % 3 == 0) ? 32'd1 : 32'd2, 32'h9000_0000 + 32'(i));
            if (i % 3 == 0) expQ.push_back(32'h9000_0000 + 32'(i));
            tick();
            clrBranch();
            if (i % 3 == 0) tick();
        end
        chk("stat_branch_cnt", stat_branch_cnt, 32'd10);
        chk("stat_taken_cnt", stat_taken_cnt, 32'd4);
`endif

        tick(); tick();
        chk("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
